// File: rtl/cbus_arbiter_pkg.sv
// Shared cache-bus types and constants for the cbus arbiter.
//   cbus_req_t   : 151-bit request from a cache-side master (or to the AXI bridge)
//   cbus_resp_t  : 66-bit response beat from the AXI bridge (or to a master)
//   cbus_arb_state_t : arbiter FSM state encoding
//   CBUS_MASTERS / CBUS_M_* : default master count and master slot indices
package cbus_arbiter_pkg;

   parameter int CBUS_MASTERS  = 3;
   parameter int CBUS_M_ICACHE = 0;
   parameter int CBUS_M_DCACHE = 1;
   parameter int CBUS_M_PTW    = 2;

   // len holds beats-1, so a single-beat burst is len == MLEN1.
   localparam logic [7:0] MLEN1 = 8'd0;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic {ARB_IDLE, ARB_BUSY} cbus_arb_state_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [7:0]  strobe;
      logic [63:0] data;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter_if.sv
// Bus bundle between the cache/MMU masters, the arbiter and the AXI bridge.
//   ireq[]    : per-master requests          (masters -> arbiter)
//   iresp[]   : per-master responses         (arbiter -> masters)
//   oreq      : request to the AXI bridge    (arbiter -> bridge)
//   oresp     : response from the AXI bridge (bridge  -> arbiter)
//   busy      : a burst is currently granted
//   grant_idx : index of the current or most recent grant
// Modport slave is the arbiter's view; modport master is the surrounding
// environment (masters plus bridge) that drives the arbiter.
interface cbus_arbiter_if
   import cbus_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = CBUS_MASTERS
);

   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   cbus_req_t              ireq  [NUM_MASTERS];
   cbus_resp_t             iresp [NUM_MASTERS];
   cbus_req_t              oreq;
   cbus_resp_t             oresp;
   logic                   busy;
   logic [IDX_W-1:0]       grant_idx;

   modport slave (
      input  ireq,
      input  oresp,
      output iresp,
      output oreq,
      output busy,
      output grant_idx
   );

   modport master (
      output ireq,
      output oresp,
      input  iresp,
      input  oreq,
      input  busy,
      input  grant_idx
   );

endinterface

// File: rtl/cbus_arbiter_rr_picker.sv
// Combinational round-robin selector.
//   req        : request vector, one bit per requester
//   last_grant : index granted most recently
//   found      : at least one request is pending
//   winner     : first requester at or after last_grant+1, wrapping at N
module cbus_arbiter_rr_picker #(
   parameter int N     = 3,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last_grant,
   output logic             found,
   output logic [IDX_W-1:0] winner
);

   always_comb begin
      int cand;
      found  = 1'b0;
      winner = '0;
      cand   = 0;
      // Walk priority order starting just after last_grant; first hit wins.
      for (int k = 1; k <= N; k++) begin
         cand = int'(last_grant) + k;
         if (cand >= N) cand = cand - N;
         if (cand >= N) cand = cand - N;
         for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (cand == i)) begin
               found  = 1'b1;
               winner = IDX_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing the cache bus between I-cache, D-cache and
// the MMU page-table walker. A grant is held for a whole burst (until the
// response beat carrying last) or until the granted master drops valid.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : cbus_arbiter_if.slave (ireq/iresp per master, oreq/oresp to
//           the AXI bridge, busy, grant_idx)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ARB_IDLE | no grant; oreq and all iresp are zero; arbitrate requests
// ARB_BUSY | grant_idx owns the bus; req/resp routed combinationally
module cbus_arbiter
   import cbus_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = CBUS_MASTERS
) (
   input  logic          clk,
   input  logic          reset,
   cbus_arbiter_if.slave bus
);

   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam logic [IDX_W-1:0] LAST_GRANT_RST = IDX_W'(NUM_MASTERS - 1);

   cbus_arb_state_t   state_q, state_d;
   logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
   logic [IDX_W-1:0]  last_grant_q, last_grant_d;

   logic [NUM_MASTERS-1:0] req_vec;
   logic                   pick_found;
   logic [IDX_W-1:0]       pick_idx;
   cbus_req_t              granted_req;

   always_comb begin
      req_vec = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         req_vec[i] = bus.ireq[i].valid;
      end
   end

   cbus_arbiter_rr_picker #(
      .N     (NUM_MASTERS),
      .IDX_W (IDX_W)
   ) u_picker (
      .req        (req_vec),
      .last_grant (last_grant_q),
      .found      (pick_found),
      .winner     (pick_idx)
   );

   always_comb begin
      granted_req = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant_idx_q == IDX_W'(i)) granted_req = bus.ireq[i];
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_idx_d  = grant_idx_q;
      last_grant_d = last_grant_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_found) begin
               state_d      = ARB_BUSY;
               grant_idx_d  = pick_idx;
               last_grant_d = pick_idx;
            end
         end
         ARB_BUSY: begin
            // A master dropping valid mid-burst is an abort and frees the bus.
            if (!granted_req.valid || (bus.oresp.ready && bus.oresp.last)) begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ARB_IDLE;
         grant_idx_q  <= '0;
         last_grant_q <= LAST_GRANT_RST;
      end else begin
         state_q      <= state_d;
         grant_idx_q  <= grant_idx_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Response data is broadcast while busy; only the owner sees ready/last.
   always_comb begin
      bus.oreq = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         bus.iresp[i] = '0;
      end
      if (state_q == ARB_BUSY) begin
         bus.oreq = granted_req;
         for (int i = 0; i < NUM_MASTERS; i++) begin
            bus.iresp[i].data = bus.oresp.data;
            if (grant_idx_q == IDX_W'(i)) begin
               bus.iresp[i].ready = bus.oresp.ready;
               bus.iresp[i].last  = bus.oresp.last;
            end
         end
      end
   end

   assign bus.busy      = (state_q == ARB_BUSY);
   assign bus.grant_idx = grant_idx_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Randomized bench for cbus_arbiter against a transaction-level ownership model.
module tb_cbus_arbiter;
   import cbus_arbiter_pkg::*;

   localparam int NM   = 3;
   localparam int NCYC = 3000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cbus_arbiter_if #(.NUM_MASTERS(NM)) bus ();

   cbus_arbiter #(.NUM_MASTERS(NM)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_chk = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
      end
   endtask

   // Model: who owns the bus (-1 = nobody), who was granted last, grant_idx.
   int owner;
   int last_g;
   int gidx;
   int bcnt;
   bit done_f  [NM];

   // Master-side stimulus state.
   bit        act      [NM];
   cbus_req_t mreq     [NM];
   int        abort_at [NM];
   int        beats    [NM];
   bit        rand_phase;

   int  dq[$];
   bit  prev_busy;

   task automatic set_inputs(input int cyc);
      bit        aborted;
      cbus_req_t r;
      reset = (cyc < 2) || (rand_phase && ($urandom_range(0, 199) == 0));
      for (int i = 0; i < NM; i++) begin
         aborted = 1'b0;
         if (done_f[i]) act[i] = 1'b0;
         if (act[i] && owner == i && abort_at[i] >= 0 && beats[i] >= abort_at[i]) begin
            act[i]  = 1'b0;
            aborted = 1'b1;
         end
         if (!act[i]) begin
            r          = '0;
            r.is_write = 1'($urandom_range(0, 1));
            r.addr     = {$urandom, $urandom};
            r.size     = 3'd3;
            r.burst    = BURST_INCR;
            r.strobe   = 8'($urandom);
            r.data     = {$urandom, $urandom};
            if (!aborted && cyc >= 2 &&
                ((!rand_phase && cyc == 2) || (rand_phase && $urandom_range(0, 99) < 30))) begin
               r.valid     = 1'b1;
               r.len       = rand_phase ? 8'($urandom_range(0, 15)) : 8'd3;
               abort_at[i] = (rand_phase && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, r.len)) : -1;
               beats[i]    = 0;
               act[i]      = 1'b1;
            end else begin
               r.len = 8'($urandom);
            end
            mreq[i] = r;
         end
         bus.ireq[i] = mreq[i];
      end
      if (owner >= 0 && bus.ireq[owner].valid) begin
         bus.oresp.ready = ($urandom_range(0, 99) < 70);
         bus.oresp.data  = bus.oresp.ready ? 64'(bcnt + 1) : {$urandom, $urandom};
         bus.oresp.last  = bus.oresp.ready && (bcnt == int'(bus.ireq[owner].len));
      end else begin
         bus.oresp.ready = 1'($urandom_range(0, 1));
         bus.oresp.last  = 1'($urandom_range(0, 1));
         bus.oresp.data  = {$urandom, $urandom};
      end
   endtask

   task automatic compare();
      cbus_req_t  eo;
      cbus_resp_t er;
      eo = (owner >= 0) ? bus.ireq[owner] : '0;
      check("oreq", bus.oreq, eo);
      for (int i = 0; i < NM; i++) begin
         er = '0;
         if (owner >= 0) begin
            er.data = bus.oresp.data;
            if (owner == i) er = bus.oresp;
         end
         check($sformatf("iresp%0d", i), bus.iresp[i], er);
      end
      check("busy", bus.busy, owner >= 0);
      check("grant_idx", bus.grant_idx, gidx);
      if (bus.busy === 1'b1 && !prev_busy) dq.push_back(int'(bus.grant_idx));
      prev_busy = (bus.busy === 1'b1);
   endtask

   task automatic model_step();
      int c;
      for (int i = 0; i < NM; i++) done_f[i] = 1'b0;
      if (reset) begin
         owner  = -1;
         last_g = NM - 1;
         gidx   = 0;
         for (int i = 0; i < NM; i++) act[i] = 1'b0;
         return;
      end
      if (owner >= 0) begin
         if (bus.oresp.ready) begin
            beats[owner]++;
            bcnt++;
         end
         if (!bus.ireq[owner].valid) begin
            owner = -1;
         end else if (bus.oresp.ready && bus.oresp.last) begin
            done_f[owner] = 1'b1;
            owner         = -1;
         end
      end else begin
         for (int k = 1; k <= NM; k++) begin
            c = (last_g + k) % NM;
            if (owner < 0 && bus.ireq[c].valid) begin
               owner  = c;
               last_g = c;
               gidx   = c;
               bcnt   = 0;
            end
         end
      end
   endtask

   initial begin
      reset      = 1'b1;
      rand_phase = 1'b0;
      prev_busy  = 1'b0;
      owner      = -1;
      last_g     = NM - 1;
      gidx       = 0;
      bcnt       = 0;
      for (int i = 0; i < NM; i++) begin
         act[i]      = 1'b0;
         done_f[i]   = 1'b0;
         mreq[i]     = '0;
         abort_at[i] = -1;
         beats[i]    = 0;
         bus.ireq[i] = '0;
      end
      bus.oresp = '0;
      @(posedge clk);
      #1;

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         if (cyc == 100) begin
            // All three requested together right after reset: expect 0, 1, 2.
            check("first_grants_seen", dq.size() >= 3, 1'b1);
            for (int k = 0; k < 3; k++) begin
               if (k < dq.size()) check($sformatf("grant_order%0d", k), dq[k], k);
            end
            rand_phase = 1'b1;
         end
         set_inputs(cyc);
         @(negedge clk);
         compare();
         model_step();
         @(posedge clk);
         #1;
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
